// File: rtl/var_range_table.sv
// Per-variable inclusive index range table with a 1-cycle lookup port and a
// walker that streams every index of one variable's range over a valid/ready port.
module var_range_table #(
    parameter  int NUM_VARS = 64,
    parameter  int IDX_W    = 16,
    localparam int VAR_W    = $clog2(NUM_VARS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [VAR_W-1:0] wr_var,
    input  logic [IDX_W-1:0] wr_start,
    input  logic [IDX_W-1:0] wr_end,
    input  logic             rd_en,
    input  logic [VAR_W-1:0] rd_var,
    output logic             rd_valid,
    output logic             rd_hit,
    output logic [IDX_W-1:0] rd_start,
    output logic [IDX_W-1:0] rd_end,
    input  logic             walk_go,
    input  logic [VAR_W-1:0] walk_var,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_last,
    output logic             walk_busy,
    output logic             walk_done,
    output logic             walk_miss
);
    localparam logic [VAR_W:0] NV = (VAR_W+1)'(NUM_VARS);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EMIT, S_DONE} state_t;

    logic [NUM_VARS-1:0] valid_q;
    logic [IDX_W-1:0]    start_mem [NUM_VARS];
    logic [IDX_W-1:0]    end_mem   [NUM_VARS];

    logic wr_ok, rd_in, wk_in;
    assign wr_ok = wr_en && ({1'b0, wr_var} < NV);
    assign rd_in = {1'b0, rd_var} < NV;

    // Table storage; only the valid bits need clearing on reset.
    always_ff @(posedge clock) begin
        if (reset) valid_q <= '0;
        else if (wr_ok) valid_q[wr_var] <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            start_mem[wr_var] <= wr_start;
            end_mem[wr_var]   <= wr_end;
        end
    end

    // Lookup port
    logic             rd_valid_q, rd_hit_q, rd_hit_d;
    logic [IDX_W-1:0] rd_start_q, rd_start_d, rd_end_q, rd_end_d;

    always_comb begin
        rd_hit_d   = 1'b0;
        rd_start_d = '0;
        rd_end_d   = '0;
        if (rd_en) begin
            if (wr_ok && wr_var == rd_var) begin
                rd_hit_d   = 1'b1;
                rd_start_d = wr_start;
                rd_end_d   = wr_end;
            end else if (rd_in && valid_q[rd_var]) begin
                rd_hit_d   = 1'b1;
                rd_start_d = start_mem[rd_var];
                rd_end_d   = end_mem[rd_var];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_start_q <= '0;
            rd_end_q   <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_hit_q   <= rd_hit_d;
            rd_start_q <= rd_start_d;
            rd_end_q   <= rd_end_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_hit   = rd_hit_q;
    assign rd_start = rd_start_q;
    assign rd_end   = rd_end_q;

    // Walker
    state_t           state_q, state_d;
    logic [VAR_W-1:0] wvar_q, wvar_d;
    logic [IDX_W-1:0] cur_q, cur_d, wend_q, wend_d;
    logic             miss_q, miss_d;
    logic             wk_hit;
    logic [IDX_W-1:0] wk_start, wk_end;

    assign wk_in = {1'b0, wvar_q} < NV;

    // Entry snapshot for the LOOKUP cycle, with the same write bypass as the read port.
    always_comb begin
        wk_hit   = 1'b0;
        wk_start = '0;
        wk_end   = '0;
        if (wr_ok && wr_var == wvar_q) begin
            wk_hit   = 1'b1;
            wk_start = wr_start;
            wk_end   = wr_end;
        end else if (wk_in && valid_q[wvar_q]) begin
            wk_hit   = 1'b1;
            wk_start = start_mem[wvar_q];
            wk_end   = end_mem[wvar_q];
        end
    end

    always_comb begin
        state_d   = state_q;
        wvar_d    = wvar_q;
        cur_d     = cur_q;
        wend_d    = wend_q;
        miss_d    = miss_q;
        idx_valid = 1'b0;
        idx_out   = '0;
        idx_last  = 1'b0;
        walk_done = 1'b0;
        walk_miss = 1'b0;
        walk_busy = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (walk_go) begin
                    wvar_d  = walk_var;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                miss_d  = !wk_hit;
                cur_d   = wk_start;
                wend_d  = wk_end;
                state_d = (!wk_hit || wk_start > wk_end) ? S_DONE : S_EMIT;
            end
            S_EMIT: begin
                idx_valid = 1'b1;
                idx_out   = cur_q;
                // Compare before increment so an end of all-ones stops without wrapping.
                idx_last  = (cur_q == wend_q);
                if (idx_ready) begin
                    if (idx_last) state_d = S_DONE;
                    else          cur_d   = cur_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                walk_done = 1'b1;
                walk_miss = miss_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            wvar_q  <= '0;
            cur_q   <= '0;
            wend_q  <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wvar_q  <= wvar_d;
            cur_q   <= cur_d;
            wend_q  <= wend_d;
            miss_q  <= miss_d;
        end
    end
endmodule

// File: tb/tb_var_range_table.sv
// Bench for var_range_table: directed vector table, hand-written walk/reset
// sequences and randomized traffic checked against an array-based model.
module tb_var_range_table;
    localparam int NV = 64;
    localparam int IW = 16;
    localparam int VW = 6;

    logic          clock = 1'b0;
    logic          reset, wr_en, rd_en, walk_go, idx_ready;
    logic [VW-1:0] wr_var, rd_var, walk_var;
    logic [IW-1:0] wr_start, wr_end;
    logic          rd_valid, rd_hit, idx_valid, idx_last, walk_busy, walk_done, walk_miss;
    logic [IW-1:0] rd_start, rd_end, idx_out;

    var_range_table #(.NUM_VARS(NV), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_var(wr_var), .wr_start(wr_start), .wr_end(wr_end),
        .rd_en(rd_en), .rd_var(rd_var),
        .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_start(rd_start), .rd_end(rd_end),
        .walk_go(walk_go), .walk_var(walk_var),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_out(idx_out), .idx_last(idx_last),
        .walk_busy(walk_busy), .walk_done(walk_done), .walk_miss(walk_miss)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: plain arrays of the table contents.
    bit            m_v [NV];
    logic [IW-1:0] m_s [NV];
    logic [IW-1:0] m_e [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mclear();
        for (int i = 0; i < NV; i++) m_v[i] = 1'b0;
    endtask

    task automatic wr(input int v, input int s, input int e);
        wr_en    = 1'b1;
        wr_var   = v[VW-1:0];
        wr_start = s[IW-1:0];
        wr_end   = e[IW-1:0];
        m_v[v] = 1'b1;
        m_s[v] = s[IW-1:0];
        m_e[v] = e[IW-1:0];
    endtask

    task automatic idle_in();
        wr_en = 0; rd_en = 0; walk_go = 0; idx_ready = 0;
        wr_var = 0; rd_var = 0; walk_var = 0; wr_start = 0; wr_end = 0;
    endtask

    task automatic walk(input int v, input int mode, input bit lk_wr, input bit noise);
        logic [IW-1:0] got[$];
        logic [IW-1:0] expq[$];
        bit ev, miss, fin, prev_stall;
        int es, ee, ndone, nval, nlast, holdbad, lastbad, dbad, nv2;
        logic [IW-1:0] prev_out;
        miss = 0; fin = 0; prev_stall = 0; prev_out = '0;
        ndone = 0; nval = 0; nlast = 0; holdbad = 0; lastbad = 0; dbad = 0;
        walk_go = 1; walk_var = v[VW-1:0];
        step();
        walk_go = 0;
        chk("walk_busy_lookup", walk_busy, 1);
        // A write landing in the LOOKUP cycle must be part of the snapshot.
        if (lk_wr) begin
            es = $urandom_range(0, 300);
            wr(v, es, es + $urandom_range(0, 6) - 1);
        end else wr_en = 0;
        ev = m_v[v]; es = int'(m_s[v]); ee = int'(m_e[v]);
        step();
        for (int k = 0; k < 400 && !fin; k++) begin
            idx_ready = (mode == 0) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
            walk_go   = (k == 1);
            walk_var  = 6'd40;
            if (noise && $urandom_range(0, 2) == 0) begin
                nv2 = ($urandom_range(0, 1) == 0) ? v : int'($urandom_range(0, 15));
                wr(nv2, $urandom_range(0, 500), $urandom_range(0, 500));
            end else wr_en = 0;
            if (idx_valid) begin
                nval++;
                if (prev_stall && idx_out !== prev_out) holdbad++;
                if (idx_ready) begin
                    got.push_back(idx_out);
                    if (idx_last !== (idx_out == ee[IW-1:0])) lastbad++;
                    if (idx_last) nlast++;
                end
            end
            prev_stall = idx_valid && !idx_ready;
            prev_out   = idx_out;
            if (walk_done) begin
                ndone++;
                miss = walk_miss;
                fin  = 1;
            end
            step();
        end
        wr_en = 0; idx_ready = 0; walk_go = 0;
        chk("walk_timeout", fin, 1);
        chk("walk_done_single", walk_done, 0);
        chk("walk_idle_after", walk_busy, 0);
        if (ev && es <= ee) for (int i = es; i <= ee; i++) expq.push_back(i[IW-1:0]);
        chk("walk_len", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] !== expq[i]) dbad++;
        chk("walk_data", dbad, 0);
        chk("walk_miss", miss, !ev);
        chk("walk_ndone", ndone, 1);
        chk("walk_hold", holdbad, 0);
        chk("walk_last_pos", lastbad, 0);
        chk("walk_last_cnt", nlast, (expq.size() > 0) ? 1 : 0);
        chk("walk_no_idx", nval == 0, expq.size() == 0);
    endtask

    typedef struct {
        bit we; int wv; int ws; int wen;
        bit re; int rv;
        bit ev; bit eh; int es; int ee;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   rv, es, ee;
        bit   eh;

        // Directed vectors, applied straight after reset.
        vecs.push_back('{0, 0, 0, 0,    1, 5,  1, 0, 0, 0});
        vecs.push_back('{1, 18, 12, 19, 0, 0,  0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0,    1, 18, 1, 1, 12, 19});
        vecs.push_back('{1, 11, 2, 5,   0, 0,  0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0,    1, 18, 1, 1, 12, 19});
        vecs.push_back('{0, 0, 0, 0,    1, 11, 1, 1, 2, 5});
        vecs.push_back('{1, 7, 30, 31,  1, 7,  1, 1, 30, 31});
        vecs.push_back('{0, 0, 0, 0,    0, 0,  0, 0, 0, 0});
        vecs.push_back('{1, 20, 9, 3,   1, 18, 1, 1, 12, 19});
        vecs.push_back('{0, 0, 0, 0,    1, 20, 1, 1, 9, 3});
        vecs.push_back('{0, 0, 0, 0,    1, 40, 1, 0, 0, 0});

        idle_in();
        mclear();
        // Reset wins over a simultaneous write, read and walk request.
        reset = 1; wr_en = 1; wr_var = 6'd5; wr_start = 16'd1; wr_end = 16'd2;
        rd_en = 1; rd_var = 6'd5; walk_go = 1; walk_var = 6'd5;
        step();
        idle_in();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_hit", rd_hit, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_rd_end", rd_end, 0);
        chk("rst_idx_valid", idx_valid, 0);
        chk("rst_idx_out", idx_out, 0);
        chk("rst_idx_last", idx_last, 0);
        chk("rst_busy", walk_busy, 0);
        chk("rst_done", walk_done, 0);
        chk("rst_miss", walk_miss, 0);
        step();
        reset = 0;

        foreach (vecs[i]) begin
            wr_en = 0;
            if (vecs[i].we) wr(vecs[i].wv, vecs[i].ws, vecs[i].wen);
            rd_en = vecs[i].re; rd_var = vecs[i].rv[VW-1:0];
            step();
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].ev);
            chk($sformatf("vec%0d_rd_hit", i), rd_hit, vecs[i].eh);
            chk($sformatf("vec%0d_rd_start", i), rd_start, vecs[i].es);
            chk($sformatf("vec%0d_rd_end", i), rd_end, vecs[i].ee);
        end
        idle_in();
        step();

        walk(11, 0, 0, 0);  // 2..5 with ready toggling
        walk(40, 0, 0, 0);  // never written -> miss
        walk(20, 0, 0, 0);  // (9,3) -> empty, no miss
        wr(3, 16'hFFFD, 16'hFFFF);
        step();
        wr_en = 0;
        walk(3, 1, 0, 0);   // top of index space, no wrap

        // Reset in the middle of an EMIT phase aborts with no done pulse.
        walk_go = 1; walk_var = 6'd18;
        step();
        walk_go = 0;
        step();
        step();
        chk("abort_pre_emit", idx_valid, 1);
        reset = 1;
        step();
        reset = 0;
        mclear();
        chk("abort_busy", walk_busy, 0);
        chk("abort_idx_valid", idx_valid, 0);
        chk("abort_done", walk_done, 0);
        step();
        chk("abort_done_late", walk_done, 0);
        rd_en = 1; rd_var = 6'd18;
        step();
        rd_en = 0;
        chk("abort_rd_valid", rd_valid, 1);
        chk("abort_rd_hit", rd_hit, 0);

        // Random read/write traffic against the model, bypass included.
        for (int c = 0; c < 300; c++) begin
            wr_en = 0;
            rv = $urandom_range(0, 15);
            rd_en = 1'($urandom_range(0, 1));
            rd_var = rv[VW-1:0];
            if (rd_en && $urandom_range(0, 2) == 0) wr(rv, $urandom_range(0, 900), $urandom_range(0, 900));
            else if ($urandom_range(0, 1) == 0) wr($urandom_range(0, 15), $urandom_range(0, 900), $urandom_range(0, 900));
            eh = rd_en && m_v[rv];
            es = eh ? int'(m_s[rv]) : 0;
            ee = eh ? int'(m_e[rv]) : 0;
            step();
            chk("rnd_rd_valid", rd_valid, rd_en);
            chk("rnd_rd_hit", rd_hit, eh);
            chk("rnd_rd_start", rd_start, es);
            chk("rnd_rd_end", rd_end, ee);
        end
        idle_in();
        step();

        // Random walks with writes racing the walker.
        for (int w = 0; w < 12; w++) begin
            rv = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 0) begin
                es = $urandom_range(0, 200);
                wr(rv, es, es + $urandom_range(0, 7) - 1);
                step();
                wr_en = 0;
            end
            walk(rv, 1, 1'($urandom_range(0, 1)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
